// File: rtl/serie_div_seq.sv
// rtl/serie_div_seq.sv - sequential alternating-series quotient engine
//
// Computes v = m/a - m/(a+2) + m/(a+4) - ... over 2*N_TERMS terms, with
// m = 4 << FRAC_BITS, using one shared restoring divider stepped one
// quotient bit per cycle and a signed-alternating accumulator.
//
// Ports:
//   clk_2   in   1        clock, all state on rising edge
//   reset   in   1        synchronous, active-high
//   start   in   1        request, sampled only while idle
//   a       in   A_BITS   divisor base, captured on accepted start
//   busy    out  1        computation in progress
//   done    out  1        one-cycle pulse, result valid
//   err     out  1        a was zero on last accepted start
//   result  out  V_BITS   accumulated series value, held until next finish
//   term    out  4        index of the term being processed, 0 when idle
module serie_div_seq #(
   parameter int A_BITS    = 8,
   parameter int N_TERMS   = 4,
   parameter int FRAC_BITS = 60,
   parameter int V_BITS    = 64
) (
   input  logic              clk_2,
   input  logic              reset,
   input  logic              start,
   input  logic [A_BITS-1:0] a,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [V_BITS-1:0] result,
   output logic [3:0]        term
);

   localparam int MW = FRAC_BITS + 3;
   localparam int DW = A_BITS + 4;
   localparam int CW = $clog2(MW + 1);

   localparam logic [MW-1:0] M_VAL  = {3'b100, {FRAC_BITS{1'b0}}};
   localparam logic [3:0]    K_LAST = 4'(2 * N_TERMS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIV,
      S_ACC,
      S_FIN
   } state_t;

   state_t            r_state;
   logic [A_BITS-1:0] r_a;
   logic [3:0]        r_k;
   logic              r_err_pend;
   logic [DW-1:0]     r_rem;
   logic [MW-1:0]     r_quo;
   logic [DW-1:0]     r_div;
   logic [CW-1:0]     r_cnt;
   logic [V_BITS-1:0] r_acc;

   logic [DW:0]       w_shift;
   logic [DW:0]       w_diff;
   logic              w_ge;
   logic [DW-1:0]     w_div_next;
   logic [V_BITS-1:0] w_q_ext;
   logic              w_in_term;

   // Remainder stays below the divisor, so the shifted value fits DW+1 bits
   // and the top bit of the difference is a clean borrow flag.
   assign w_shift    = {r_rem, r_quo[MW-1]};
   assign w_diff     = w_shift - {1'b0, r_div};
   assign w_ge       = ~w_diff[DW];
   assign w_div_next = DW'(r_a) + (DW'(r_k) << 1);
   assign w_q_ext    = V_BITS'(r_quo);
   assign w_in_term  = (r_state == S_LOAD) || (r_state == S_DIV) || (r_state == S_ACC);

   assign term = w_in_term ? r_k : 4'd0;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_k        <= '0;
         r_err_pend <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div      <= '0;
         r_cnt      <= '0;
         r_acc      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         result     <= '0;
      end else begin
         done <= 1'b0;
         // busy lags the state by one cycle: high from the cycle after
         // acceptance, low together with the done pulse.
         busy <= w_in_term;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a        <= a;
                  r_acc      <= '0;
                  r_k        <= '0;
                  r_err_pend <= (a == '0);
                  r_state    <= (a == '0) ? S_FIN : S_LOAD;
               end
            end
            S_LOAD: begin
               r_rem   <= '0;
               r_quo   <= M_VAL;
               r_div   <= w_div_next;
               r_cnt   <= CW'(MW);
               r_state <= S_DIV;
            end
            S_DIV: begin
               // Dividend bits shift out of the top of r_quo while quotient
               // bits shift in at the bottom.
               r_rem   <= w_ge ? w_diff[DW-1:0] : w_shift[DW-1:0];
               r_quo   <= {r_quo[MW-2:0], w_ge};
               r_cnt   <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_ACC;
               end
            end
            S_ACC: begin
               r_acc <= r_k[0] ? (r_acc - w_q_ext) : (r_acc + w_q_ext);
               if (r_k == K_LAST) begin
                  r_state <= S_FIN;
               end else begin
                  r_k     <= r_k + 4'd1;
                  r_state <= S_LOAD;
               end
            end
            S_FIN: begin
               result  <= r_err_pend ? '0 : r_acc;
               err     <= r_err_pend;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serie_div_seq.sv
// tb/tb_serie_div_seq.sv - self-checking bench for serie_div_seq
//
// Two instances: d=0 small (N_TERMS=1, FRAC_BITS=4, m=64), d=1 defaults.
// A transaction-level model predicts done/busy/err/result/term every cycle.
module tb_serie_div_seq;

   logic        clk;
   logic [1:0]  rst_s;
   logic [1:0]  start_s;
   logic [7:0]  a_s    [2];
   logic [1:0]  busy_s;
   logic [1:0]  done_s;
   logic [1:0]  err_s;
   logic [63:0] res_s  [2];
   logic [3:0]  term_s [2];

   int n_tests = 0;
   int n_fail  = 0;

   serie_div_seq #(.A_BITS(8), .N_TERMS(1), .FRAC_BITS(4), .V_BITS(64)) u_small (
      .clk_2 (clk),
      .reset (rst_s[0]),
      .start (start_s[0]),
      .a     (a_s[0]),
      .busy  (busy_s[0]),
      .done  (done_s[0]),
      .err   (err_s[0]),
      .result(res_s[0]),
      .term  (term_s[0])
   );

   serie_div_seq u_dflt (
      .clk_2 (clk),
      .reset (rst_s[1]),
      .start (start_s[1]),
      .a     (a_s[1]),
      .busy  (busy_s[1]),
      .done  (done_s[1]),
      .err   (err_s[1]),
      .result(res_s[1]),
      .term  (term_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_val(input int d, input int av);
      longint unsigned m, s, q;
      int nt;
      m  = (d == 0) ? 64'd64 : (64'd1 << 62);
      nt = (d == 0) ? 2 : 8;
      s  = 0;
      for (int k = 0; k < nt; k++) begin
         q = m / longint'(av + 2 * k);
         s = (k % 2 == 1) ? s - q : s + q;
      end
      return s;
   endfunction

   // cycles per term (load + divide bits + accumulate)
   function automatic int per_term(input int d);
      return (d == 0) ? 9 : 65;
   endfunction

   function automatic int lat_of(input int d, input int av);
      if (av == 0) return 1;
      return (d == 0) ? 2 * 1 * 9 + 1 : 2 * 4 * 65 + 1;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   int          cnt      [2];
   int          lat_cur  [2];
   logic [7:0]  cur_a    [2];
   logic        ed       [2];
   logic        eb       [2];
   logic        ee       [2];
   logic [63:0] er       [2];
   logic [3:0]  et       [2];
   bit          seen_rst [2];
   int          done_cnt [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         cnt[d] = 0; seen_rst[d] = 0; done_cnt[d] = 0;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ed[d] = 1'b0;
         if (rst_s[d]) begin
            cnt[d] = 0; eb[d] = 0; ee[d] = 0; er[d] = '0; et[d] = '0;
            seen_rst[d] = 1;
         end else if (cnt[d] == 0) begin
            eb[d] = 0; et[d] = '0;
            if (start_s[d]) begin
               cur_a[d]   = a_s[d];
               lat_cur[d] = lat_of(d, int'(a_s[d]));
               cnt[d]     = 1;
            end
         end else if (cnt[d] == lat_cur[d]) begin
            ed[d]  = 1'b1;
            eb[d]  = 1'b0;
            ee[d]  = (cur_a[d] == 8'd0);
            er[d]  = (cur_a[d] == 8'd0) ? 64'd0 : model_val(d, int'(cur_a[d]));
            et[d]  = '0;
            cnt[d] = 0;
         end else begin
            eb[d]  = 1'b1;
            et[d]  = (cnt[d] <= lat_cur[d] - 2) ? 4'(cnt[d] / per_term(d)) : 4'd0;
            cnt[d] = cnt[d] + 1;
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         if (seen_rst[d]) begin
            n_tests++;
            if ({done_s[d], busy_s[d], err_s[d], res_s[d], term_s[d]} !==
                {ed[d], eb[d], ee[d], er[d], et[d]}) begin
               n_fail++;
               $display("FAIL cycle d%0d t=%0t: done=%b busy=%b err=%b result=%h term=%0d, expected done=%b busy=%b err=%b result=%h term=%0d",
                        d, $time, done_s[d], busy_s[d], err_s[d], res_s[d], term_s[d],
                        ed[d], eb[d], ee[d], er[d], et[d]);
            end
            if (done_s[d] === 1'b1) done_cnt[d]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run(input int d, input int av, input bit noise, output int lat);
      @(negedge clk);
      start_s[d] = 1'b1;
      a_s[d]     = 8'(av);
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
      lat = 0;
      while (lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
         if (done_s[d] === 1'b1) break;
         if (noise) begin
            start_s[d] = 1'($urandom_range(0, 1));
            a_s[d]     = 8'($urandom);
         end
      end
      start_s[d] = 1'b0;
      if (done_s[d] !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_timeout d%0d a=%0d: no done within 1000 cycles", d, av);
      end
   endtask

   int lat;
   int c0;
   int av;

   initial begin
      rst_s   = 2'b11;
      start_s = 2'b00;
      a_s[0]  = 8'd0;
      a_s[1]  = 8'd0;
      repeat (3) @(negedge clk);
      rst_s = 2'b00;

      // model pinned to hand-computed values
      check("model_a1", model_val(0, 1), 64'h2B);
      check("model_a2", model_val(0, 2), 64'h10);
      check("model_a3", model_val(0, 3), 64'd9);
      check("model_a255", model_val(0, 255), 64'd0);

      // T1
      run(0, 1, 0, lat);
      check("t1_lat", 64'(lat), 64'd19);
      check("t1_res", res_s[0], 64'h2B);
      check("t1_err", 64'(err_s[0]), 64'd0);
      // T2
      run(0, 2, 0, lat);
      check("t2_res_a2", res_s[0], 64'h10);
      run(0, 255, 0, lat);
      check("t2_res_a255", res_s[0], 64'd0);
      // T3
      run(0, 0, 0, lat);
      check("t3_lat", 64'(lat), 64'd1);
      check("t3_err", 64'(err_s[0]), 64'd1);
      check("t3_res", res_s[0], 64'd0);
      run(0, 1, 0, lat);
      check("t3_err_clear", 64'(err_s[0]), 64'd0);
      check("t3_res_after", res_s[0], 64'h2B);

      // small-instance sweep, every third run with noise while busy
      for (int i = 1; i < 256; i++) begin
         run(0, i, (i % 3 == 0), lat);
         check("sweep_small_lat", 64'(lat), 64'd19);
      end

      // T5 back-to-back with start held high: three runs, three dones
      c0 = done_cnt[0];
      @(negedge clk);
      start_s[0] = 1'b1;
      a_s[0]     = 8'd1;
      @(posedge clk);
      repeat (40) @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("b2b_dones", 64'(done_cnt[0] - c0), 64'd3);
      check("b2b_res", res_s[0], 64'h2B);

      // T4 defaults
      run(1, 1, 0, lat);
      check("t4_lat_a1", 64'(lat), 64'd521);
      check("t4_res_a1", res_s[1], model_val(1, 1));
      run(1, 255, 0, lat);
      check("t4_lat_a255", 64'(lat), 64'd521);
      run(1, 2, 0, lat);
      run(1, 254, 0, lat);
      for (int i = 0; i < 20; i++) begin
         av = $urandom_range(1, 255);
         run(1, av, (i % 4 == 0), lat);
         check("t4_lat_rand", 64'(lat), 64'd521);
      end
      run(1, 0, 0, lat);
      check("t4_lat_a0", 64'(lat), 64'd1);

      // T5 noise on the default instance
      run(1, 77, 1, lat);
      check("t5_res_a77", res_s[1], model_val(1, 77));

      // T6 reset mid-divide
      c0 = done_cnt[1];
      @(negedge clk);
      start_s[1] = 1'b1;
      a_s[1]     = 8'd200;
      @(posedge clk);
      #1;
      start_s[1] = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_s[1] = 1'b1;
      @(posedge clk);
      #2;
      check("t6_busy", 64'(busy_s[1]), 64'd0);
      check("t6_done", 64'(done_s[1]), 64'd0);
      check("t6_res", res_s[1], 64'd0);
      check("t6_term", 64'(term_s[1]), 64'd0);
      @(negedge clk);
      rst_s[1] = 1'b0;
      repeat (600) @(posedge clk);
      @(negedge clk);
      check("t6_no_stray_done", 64'(done_cnt[1] - c0), 64'd0);
      run(1, 200, 0, lat);
      check("t6_lat", 64'(lat), 64'd521);
      check("t6_res_after", res_s[1], model_val(1, 200));

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
